vec_sqrt_seq: RTL and testbench

Lane sequencer that sits directly upstream of the BF16 square-root unit in the vector datapath. It accepts one LANES-wide vector of BF16 operands with an active-lane mask and issues the active lanes one at a time, lowest lane first, to the single-outstanding sqrt unit over its valid/ready handshake. It collects each result into the matching lane and presents the finished vector to writeback with a valid/ready handshake. Inactive lanes are never issued and return 16'h0000.

---
 rtl/vec_sqrt_seq.sv | 115 +++++++++++
 tb/tb_vec_sqrt_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_sqrt_seq.sv
// Lane sequencer ahead of the single-outstanding BF16 sqrt unit. Accepts one
// masked vector, issues active lanes lowest-first, gathers results per lane and
// hands the finished vector to writeback. Inactive lanes read back as zero.
module vec_sqrt_seq #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    vec_valid_in,
  output logic                    vec_ready_in,
  input  logic [LANES*DATA_W-1:0] vec_operand,
  input  logic [LANES-1:0]        vec_mask,
  output logic                    vec_valid_out,
  input  logic                    vec_ready_out,
  output logic [LANES*DATA_W-1:0] vec_result,
  output logic                    busy,
  output logic                    sq_valid_in,
  output logic [DATA_W-1:0]       sq_operand,
  input  logic                    sq_ready_in,
  input  logic                    sq_valid_out,
  input  logic [DATA_W-1:0]       sq_result,
  output logic                    sq_ready_out
);

  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic [LANES*DATA_W-1:0] op_q, op_d;
  logic [LANES*DATA_W-1:0] res_q, res_d;
  logic [LANES-1:0]        pend_q, pend_d;
  logic [LANES-1:0]        pend_clr;
  logic [IdxW-1:0]         idx_q, idx_d;

  // Index of the lowest set bit; zero when the mask is empty.
  function automatic logic [IdxW-1:0] lowest_lane(input logic [LANES-1:0] m);
    logic [IdxW-1:0] r;
    r = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) r = IdxW'(i);
    end
    return r;
  endfunction

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      op_q    <= '0;
      res_q   <= '0;
      pend_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic. idx_q is chosen on entry to ISSUE so the operand mux
  // is driven from registered state only.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    res_d    = res_q;
    pend_d   = pend_q;
    idx_d    = idx_q;
    pend_clr = pend_q;
    pend_clr[idx_q] = 1'b0;

    case (state_q)
      StIdle: begin
        if (vec_valid_in) begin
          op_d    = vec_operand;
          pend_d  = vec_mask;
          res_d   = '0;
          idx_d   = lowest_lane(vec_mask);
          state_d = (|vec_mask) ? StIssue : StDone;
        end
      end
      StIssue: begin
        if (sq_ready_in) state_d = StWait;
      end
      StWait: begin
        if (sq_valid_out) begin
          res_d[idx_q*DATA_W +: DATA_W] = sq_result;
          pend_d  = pend_clr;
          idx_d   = lowest_lane(pend_clr);
          state_d = (|pend_clr) ? StIssue : StDone;
        end
      end
      StDone: begin
        if (vec_ready_out) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    vec_ready_in  = (state_q == StIdle);
    busy          = (state_q != StIdle);
    sq_valid_in   = (state_q == StIssue);
    sq_ready_out  = (state_q == StWait);
    vec_valid_out = (state_q == StDone);
    vec_result    = res_q;
    // Gated so the operand bus reads zero outside ISSUE.
    sq_operand    = (state_q == StIssue) ? op_q[idx_q*DATA_W +: DATA_W] : '0;
  end

endmodule

// File: tb/tb_vec_sqrt_seq.sv
// Bench for vec_sqrt_seq: a mock sqrt unit with programmable latency and issue
// stall, directed vectors from the block's intended behaviour, then random ones.
module tb_vec_sqrt_seq;

  localparam int LANES = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              vec_valid_in = 1'b0;
  logic              vec_ready_in;
  logic [LANES*16-1:0] vec_operand = '0;
  logic [LANES-1:0]  vec_mask = '0;
  logic              vec_valid_out;
  logic              vec_ready_out = 1'b0;
  logic [LANES*16-1:0] vec_result;
  logic              busy;
  logic              sq_valid_in;
  logic [15:0]       sq_operand;
  logic              sq_ready_in = 1'b1;
  logic              sq_valid_out = 1'b0;
  logic [15:0]       sq_result = '0;
  logic              sq_ready_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  vec_sqrt_seq #(.LANES(LANES), .DATA_W(16)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .vec_valid_in  (vec_valid_in),
    .vec_ready_in  (vec_ready_in),
    .vec_operand   (vec_operand),
    .vec_mask      (vec_mask),
    .vec_valid_out (vec_valid_out),
    .vec_ready_out (vec_ready_out),
    .vec_result    (vec_result),
    .busy          (busy),
    .sq_valid_in   (sq_valid_in),
    .sq_operand    (sq_operand),
    .sq_ready_in   (sq_ready_in),
    .sq_valid_out  (sq_valid_out),
    .sq_result     (sq_result),
    .sq_ready_out  (sq_ready_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mock sqrt: exact BF16 sqrt for the directed operands, a fixed map otherwise.
  function automatic logic [15:0] mock_sqrt(input logic [15:0] x);
    case (x)
      16'h3F80: return 16'h3F80;  // 1 -> 1
      16'h4080: return 16'h4000;  // 4 -> 2
      16'h4110: return 16'h4040;  // 9 -> 3
      16'h4000: return 16'h3FB5;  // 2 -> 1.414
      default:  return {x[15:8] ^ 8'h5A, x[7:0] + 8'd1};
    endcase
  endfunction

  // Mock sqrt unit state, driven at the falling edge.
  int          mock_d     = 3;
  int          stall_left = 0;
  bit          have_res   = 1'b0;
  int          due        = 0;
  logic [15:0] res_m      = '0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_op    = '0;
  logic [15:0] log_op[$];
  int          log_cyc[$];

  always @(negedge CLK) begin
    if (RST) begin
      have_res     = 1'b0;
      sq_valid_out = 1'b0;
      sq_ready_in  = 1'b1;
      stall_left   = 0;
      prev_stall   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", sq_valid_in, 1);
        check("stall_op_held", sq_operand, prev_op);
      end
      if (sq_valid_in && stall_left > 0) begin
        sq_ready_in = 1'b0;
        stall_left--;
      end else begin
        sq_ready_in = 1'b1;
      end
      sq_valid_out = have_res && (cyc >= due);
      sq_result    = sq_valid_out ? res_m : 16'h0;
      if (sq_valid_out && sq_ready_out) have_res = 1'b0;
      if (sq_valid_in && sq_ready_in) begin
        have_res = 1'b1;
        due      = cyc + mock_d;
        res_m    = mock_sqrt(sq_operand);
        log_op.push_back(sq_operand);
        log_cyc.push_back(cyc);
      end
      prev_stall = sq_valid_in && !sq_ready_in;
      prev_op    = sq_operand;
    end
  end

  task automatic check_reset_outputs();
    check("rst_ready_in", vec_ready_in, 1);
    check("rst_valid_out", vec_valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_sq_valid_in", sq_valid_in, 0);
    check("rst_sq_ready_out", sq_ready_out, 0);
    check("rst_result", vec_result, 0);
    check("rst_sq_operand", sq_operand, 0);
  endtask

  // Drive one vector through and compare against the lane-level model.
  task automatic run_vec(input logic [63:0] ops, input logic [3:0] mask, input int d,
                         input int stall, input int hold);
    logic [63:0] exp_res;
    logic [15:0] exp_ops[$];
    int k, t0, n, lat;
    exp_res = '0;
    k = 0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        exp_res[i*16 +: 16] = mock_sqrt(ops[i*16 +: 16]);
        exp_ops.push_back(ops[i*16 +: 16]);
        k++;
      end
    end
    mock_d     = d;
    stall_left = stall;
    log_op.delete();
    log_cyc.delete();

    @(negedge CLK);
    check("idle_ready_in", vec_ready_in, 1);
    vec_valid_in = 1'b1;
    vec_operand  = ops;
    vec_mask     = mask;
    t0 = cyc;
    @(negedge CLK);
    vec_valid_in = 1'b0;
    vec_operand  = {$urandom, $urandom};
    vec_mask     = 4'($urandom);
    n = 0;
    while (!vec_valid_out && n < 400) begin
      @(negedge CLK);
      n++;
    end
    lat = cyc - t0;
    check("latency", lat, 1 + ((k > 0) ? stall : 0) + k * (d + 1));
    check("result", vec_result, exp_res);
    check("busy_in_done", busy, 1);
    check("issue_count", log_op.size(), k);
    for (int j = 0; j < k; j++) begin
      if (j < log_op.size()) begin
        check("issue_operand", log_op[j], exp_ops[j]);
        check("issue_cycle", log_cyc[j] - t0, 1 + stall + j * (d + 1));
      end
    end

    for (int h = 0; h < hold; h++) begin
      vec_valid_in = 1'($urandom_range(0, 1));
      vec_mask     = 4'($urandom);
      @(negedge CLK);
      check("hold_valid_out", vec_valid_out, 1);
      check("hold_result", vec_result, exp_res);
      check("hold_ready_in", vec_ready_in, 0);
    end
    vec_valid_in  = 1'b0;
    vec_ready_out = 1'b1;
    @(negedge CLK);
    vec_ready_out = 1'b0;
    check("post_valid_out", vec_valid_out, 0);
    check("post_ready_in", vec_ready_in, 1);
    check("post_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] dir_ops;
    int n;
    dir_ops = {16'h4000, 16'h4110, 16'h4080, 16'h3F80};

    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_reset_outputs();

    run_vec(dir_ops, 4'b1111, 3, 0, 0);
    run_vec(dir_ops, 4'b1010, 3, 0, 0);
    run_vec(dir_ops, 4'b0000, 3, 0, 0);
    run_vec(dir_ops, 4'b1111, 3, 5, 0);
    run_vec(dir_ops, 4'b1111, 3, 0, 10);

    // Reset while waiting on lane 2's result.
    mock_d = 3;
    stall_left = 0;
    log_op.delete();
    log_cyc.delete();
    @(negedge CLK);
    vec_valid_in = 1'b1;
    vec_operand  = dir_ops;
    vec_mask     = 4'b1111;
    @(negedge CLK);
    vec_valid_in = 1'b0;
    n = 0;
    while (!(log_op.size() == 3 && sq_ready_out) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("reached_lane2_wait", log_op.size(), 3);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_reset_outputs();
    run_vec(dir_ops, 4'b1111, 2, 0, 0);

    for (int r = 0; r < 8; r++) begin
      run_vec({$urandom, $urandom}, 4'($urandom), $urandom_range(1, 4),
              $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
